phase_acc: RTL and testbench

PHASE_ACC -- requirements
Module: phase_acc

---
 rtl/phase_acc.sv | 149 ++++++++++++++
 tb/tb_phase_acc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/phase_acc.sv
// Phase accumulator (NCO core) with shadowed frequency/phase updates.
// Updates made while running are held pending and take effect on the
// next accumulator overflow, so a waveform period is never cut short.
module phase_acc #(
  parameter int unsigned ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [13:0] state_freq,
  input  logic [7:0]  state_phase,
  input  logic        upd,
  output logic        upd_ack,
  output logic [13:0] cnt,
  output logic        wrap,
  output logic        busy
);

  localparam int unsigned FREQ_W  = 14;
  localparam int unsigned PHASE_W = 8;
  localparam int unsigned CNT_W   = 14;
  localparam int unsigned PAD_W   = CNT_W - PHASE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [ACC_W-1:0]     r_acc;
  logic [FREQ_W-1:0]    r_freq_a;
  logic [PHASE_W-1:0]   r_phase_a;
  logic [FREQ_W-1:0]    r_freq_s;
  logic [PHASE_W-1:0]   r_phase_s;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_wrap;
  logic                 r_ack;
  logic                 r_busy;

  logic [ACC_W:0]       w_sum;
  logic [ACC_W-1:0]     w_acc_next;
  logic                 w_carry;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [FREQ_W-1:0]    w_freq_s_next;
  logic [PHASE_W-1:0]   w_phase_s_next;
  logic                 w_commit;
  logic                 w_commit_latest;
  logic [FREQ_W-1:0]    w_freq_commit;
  logic [PHASE_W-1:0]   w_phase_commit;

  // Accumulator add with carry-out, phase-offset output word, and shadow capture.
  always_comb begin
    w_sum          = {1'b0, r_acc} + (ACC_W+1)'(r_freq_a);
    w_acc_next     = w_sum[ACC_W-1:0];
    w_carry        = w_sum[ACC_W];
    w_cnt_next     = w_acc_next[ACC_W-1 -: CNT_W] + {r_phase_a, PAD_W'(0)};
    w_freq_s_next  = upd ? state_freq  : r_freq_s;
    w_phase_s_next = upd ? state_phase : r_phase_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and update-commit decision.
  always_comb begin
    w_state_next    = r_state;
    w_commit        = 1'b0;
    w_commit_latest = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!en) begin
          w_commit        = upd;
          w_commit_latest = 1'b1;
        end else if (upd) begin
          w_state_next = ST_PEND;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en) begin
          w_state_next    = ST_IDLE;
          w_commit        = upd;
          w_commit_latest = 1'b1;
        end else if (upd) begin
          w_state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!en) begin
          // Stopping flushes the pending update, including any same-cycle request.
          w_state_next    = ST_IDLE;
          w_commit        = 1'b1;
          w_commit_latest = 1'b1;
        end else if (w_carry) begin
          // Overflow commits the prior shadow; a coincident request re-arms PEND.
          w_commit     = 1'b1;
          w_state_next = upd ? ST_PEND : ST_RUN;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_freq_commit  = w_commit_latest ? w_freq_s_next  : r_freq_s;
    w_phase_commit = w_commit_latest ? w_phase_s_next : r_phase_s;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_freq_a  <= '0;
      r_phase_a <= '0;
      r_freq_s  <= '0;
      r_phase_s <= '0;
      r_cnt     <= '0;
      r_wrap    <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_freq_s  <= w_freq_s_next;
      r_phase_s <= w_phase_s_next;
      r_ack     <= w_commit;
      r_busy    <= (w_state_next == ST_PEND);
      if (en) begin
        r_acc  <= w_acc_next;
        r_cnt  <= w_cnt_next;
        r_wrap <= w_carry;
      end else begin
        r_wrap <= 1'b0;
      end
      if (w_commit) begin
        r_freq_a  <= w_freq_commit;
        r_phase_a <= w_phase_commit;
      end
    end
  end

  assign upd_ack = r_ack;
  assign cnt     = r_cnt;
  assign wrap    = r_wrap;
  assign busy    = r_busy;

endmodule

// File: tb/tb_phase_acc.sv
// Scoreboard bench for phase_acc: directed steps push expected outputs,
// an independent monitor pops and compares one entry per clock.
module tb_phase_acc;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [13:0] state_freq;
  logic [7:0]  state_phase;
  logic        upd;
  logic        upd_ack;
  logic [13:0] cnt;
  logic        wrap;
  logic        busy;

  typedef struct {
    int          id;
    logic [13:0] cnt;
    logic        wrap;
    logic        ack;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;
  int   n_fail;
  int   step_id;

  phase_acc #(.ACC_W(24)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .state_freq  (state_freq),
    .state_phase (state_phase),
    .upd         (upd),
    .upd_ack     (upd_ack),
    .cnt         (cnt),
    .wrap        (wrap),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [13:0] got, input logic [13:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", name, id, got, want);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cnt",     e.id, cnt,             e.cnt);
      chk("wrap",    e.id, 14'(wrap),       14'(e.wrap));
      chk("upd_ack", e.id, 14'(upd_ack),    14'(e.ack));
      chk("busy",    e.id, 14'(busy),       14'(e.busy));
    end
  end

  // Drive one clock of stimulus and queue the outputs expected after that edge.
  task automatic step(input logic rn, input logic e, input logic u,
                      input logic [13:0] f, input logic [7:0] p,
                      input logic [13:0] ecnt, input logic ewrap,
                      input logic eack, input logic ebusy);
    exp_t x;
    @(negedge clk);
    rst_n       = rn;
    en          = e;
    upd         = u;
    state_freq  = f;
    state_phase = p;
    @(posedge clk);
    step_id++;
    x.id   = step_id;
    x.cnt  = ecnt;
    x.wrap = ewrap;
    x.ack  = eack;
    x.busy = ebusy;
    exp_q.push_back(x);
  endtask

  task automatic run(input logic e, input logic [13:0] ecnt, input logic ebusy);
    step(1'b1, e, 1'b0, 14'd0, 8'd0, ecnt, 1'b0, 1'b0, ebusy);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0; step_id = 0;
    rst_n = 1'b0; en = 1'b0; upd = 1'b0; state_freq = '0; state_phase = '0;

    // Reset state, with en/upd active to show reset priority.
    step(1'b0, 1'b1, 1'b1, 14'd1000, 8'hFF, 14'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 14'd0, 1'b0, 1'b0, 1'b0);

    // Idle update freq=512 phase=0x40: ack next cycle, never busy, half-rate step.
    step(1'b1, 1'b0, 1'b1, 14'd512, 8'h40, 14'd0, 1'b0, 1'b1, 1'b0);
    run(1'b0, 14'd0, 1'b0);
    run(1'b1, 14'h1000, 1'b0);
    run(1'b1, 14'h1001, 1'b0);
    run(1'b1, 14'h1001, 1'b0);
    run(1'b1, 14'h1002, 1'b0);
    run(1'b1, 14'h1002, 1'b0);
    run(1'b0, 14'h1002, 1'b0);

    // freq=1024 from reset: cnt counts by one, wrap with cnt=0 every 16384 cycles.
    step(1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 14'd1024, 8'd0, 14'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 32768; k++) begin
      logic [13:0] c;
      c = 14'(k % 16384);
      if (k == 16400)
        step(1'b1, 1'b1, 1'b1, 14'd2048, 8'd0, c, 1'b0, 1'b0, 1'b1);
      else if (k == 32768)
        step(1'b1, 1'b1, 1'b0, 14'd0, 8'd0, 14'd0, 1'b1, 1'b1, 1'b0);
      else
        step(1'b1, 1'b1, 1'b0, 14'd0, 8'd0, c, (k == 16384), 1'b0, (k > 16400));
    end
    run(1'b1, 14'd2, 1'b0);
    run(1'b1, 14'd4, 1'b0);
    run(1'b1, 14'd6, 1'b0);

    // Two requests in one pend (100 then 300), a third coinciding with the overflow.
    step(1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 14'd8192, 8'd0, 14'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 2048; k++) begin
      logic [13:0] c;
      c = 14'((8 * k) % 16384);
      if (k == 5)
        step(1'b1, 1'b1, 1'b1, 14'd100, 8'd0, c, 1'b0, 1'b0, 1'b1);
      else if (k == 10)
        step(1'b1, 1'b1, 1'b1, 14'd300, 8'd0, c, 1'b0, 1'b0, 1'b1);
      else if (k == 2048)
        step(1'b1, 1'b1, 1'b1, 14'd4096, 8'd0, 14'd0, 1'b1, 1'b1, 1'b1);
      else
        step(1'b1, 1'b1, 1'b0, 14'd0, 8'd0, c, 1'b0, 1'b0, (k > 5));
    end
    // Active freq is 300: floor(300*j/1024); still pending on the 4096 request.
    run(1'b1, 14'd0, 1'b1);
    run(1'b1, 14'd0, 1'b1);
    run(1'b1, 14'd0, 1'b1);
    run(1'b1, 14'd1, 1'b1);
    run(1'b1, 14'd1, 1'b1);
    run(1'b1, 14'd1, 1'b1);
    run(1'b1, 14'd2, 1'b1);
    run(1'b1, 14'd2, 1'b1);
    // en falls in pend: update applies with one ack, then steps of 4 (acc was 2400).
    step(1'b1, 1'b0, 1'b0, 14'd0, 8'd0, 14'd2, 1'b0, 1'b1, 1'b0);
    run(1'b0, 14'd2, 1'b0);
    run(1'b1, 14'd6, 1'b0);
    run(1'b1, 14'd10, 1'b0);
    run(1'b1, 14'd14, 1'b0);

    // freq=0 pend never completes until en drops.
    step(1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 14'd0, 8'd0, 14'd0, 1'b0, 1'b1, 1'b0);
    run(1'b1, 14'd0, 1'b0);
    run(1'b1, 14'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 14'd512, 8'h40, 14'd0, 1'b0, 1'b0, 1'b1);
    run(1'b1, 14'd0, 1'b1);
    run(1'b1, 14'd0, 1'b1);
    run(1'b1, 14'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 14'd0, 8'd0, 14'd0, 1'b0, 1'b1, 1'b0);
    run(1'b0, 14'd0, 1'b0);
    run(1'b1, 14'h1000, 1'b0);

    // Reset while busy discards the pending update.
    step(1'b1, 1'b1, 1'b1, 14'd16, 8'd0, 14'h1001, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 14'd0, 8'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 14'd0, 1'b0);
    run(1'b0, 14'd0, 1'b0);
    run(1'b0, 14'd0, 1'b0);
    run(1'b1, 14'd0, 1'b0);
    run(1'b1, 14'd0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      n_fail++;
      $display("FAIL drain: got %0d entries left want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
